// File: rtl/count_req_queue_pkg.sv
// count_req_queue_pkg: shared constants, issue-FSM state type and sizing helper
// for the count request queue.
package count_req_queue_pkg;

    // Counter register selects carried by each request.
    localparam logic SLT_REG0 = 1'b0;
    localparam logic SLT_REG1 = 1'b1;

    // Issue FSM: IDLE may issue a pulse, GAP enforces idle cycles after one.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } issue_state_t;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_1b.sv
// sync_fifo_1b: 1-bit-wide synchronous FIFO with registered occupancy.
// The caller guarantees push only when !full and pop only when !empty.
module sync_fifo_1b
    import count_req_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      push,
    input  logic                      push_data,
    input  logic                      pop,
    output logic                      pop_data,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      empty,
    output logic                      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; payload bits need no reset, the pointers qualify them.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/count_req_queue.sv
// count_req_queue: buffers 1-bit count requests and replays them as
// single-cycle En/Slt pulses with at least GAP idle cycles between pulses.
// Optional macro COUNT_REQ_QUEUE_DROP_CNT_EN adds Drop_Cnt, a saturating
// count of requests offered while the queue was full.
module count_req_queue
    import count_req_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      In_Valid,
    input  logic                      In_Slt,
    output logic                      In_Ready,
    input  logic                      Hold,
    output logic                      En,
    output logic                      Slt,
    output logic [level_w(DEPTH)-1:0] Level,
    output logic                      Empty,
    output logic                      Full
`ifdef COUNT_REQ_QUEUE_DROP_CNT_EN
    ,
    output logic [15:0]               Drop_Cnt
`endif
);

    localparam int CNT_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    issue_state_t     state;
    issue_state_t     state_nxt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_nxt;
    logic             issue;
    logic             push;
    logic             head;

    // No full-bypass: a push is refused while full even if a pop coincides.
    assign In_Ready = !Full;
    assign push     = In_Valid && In_Ready;

    sync_fifo_1b #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (push),
        .push_data(In_Slt),
        .pop      (issue),
        .pop_data (head),
        .level    (Level),
        .empty    (Empty),
        .full     (Full)
    );

    // Issue decision: pop the head when idle, non-empty and not held; then
    // sit out GAP cycles, which Hold neither extends nor aborts.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        issue       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!Empty && !Hold) begin
                    issue = 1'b1;
                    if (GAP > 0) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = CNT_W'(GAP);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= CNT_W'(1)) begin
                    state_nxt   = S_IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                gap_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and gap counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Registered pulse to the counter; Slt keeps its last value between pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            En  <= 1'b0;
            Slt <= SLT_REG0;
        end else begin
            En <= issue;
            if (issue) begin
                Slt <= head;
            end
        end
    end

`ifdef COUNT_REQ_QUEUE_DROP_CNT_EN
    // Count refused offers, holding at all-ones rather than wrapping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Drop_Cnt <= '0;
        end else if (In_Valid && Full && (Drop_Cnt != 16'hFFFF)) begin
            Drop_Cnt <= Drop_Cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_count_req_queue.sv
// tb_count_req_queue: scoreboard bench for count_req_queue with two instances,
// GAP=0 (u_gap0) and GAP=2 (u_gap2). Expected Slt values are queued as
// requests are accepted; per-instance monitors compare them against En pulses.
module tb_count_req_queue;

    localparam int DEPTH = 8;

    logic       Clk = 1'b0;
    logic       Reset;

    logic       v0, s0, h0, rdy0, en0, slt0, emp0, full0;
    logic [3:0] lvl0;
    logic       v2, s2, h2, rdy2, en2, slt2, emp2, full2;
    logic [3:0] lvl2;
`ifdef COUNT_REQ_QUEUE_DROP_CNT_EN
    logic [15:0] drop0, drop2;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    logic q0[$];
    logic q2[$];

    logic [3:0] seq1 = 4'b0110;       // issue order 0,1,1,0
    logic [9:0] pat3 = 10'b1010111001; // 1,0,0,1,1,1,0,1 accepted; 0,1 refused
    logic [4:0] pat5 = 5'b01011;      // 1,1,0,1,0
    logic [2:0] pat2 = 3'b101;        // 1,0,1
    logic [4:0] pat6 = 5'b10110;      // 0,1,1,0,1
    logic [7:0] en_exp2 = 8'b01001001; // En after each edge: 1,0,0,1,0,0,1,0
    int         lvl_exp2[8] = '{2, 2, 2, 1, 1, 1, 0, 0};

    always #5 Clk = ~Clk;

    count_req_queue #(.DEPTH(DEPTH), .GAP(0)) u_gap0 (
        .Clk(Clk), .Reset(Reset), .In_Valid(v0), .In_Slt(s0), .In_Ready(rdy0),
        .Hold(h0), .En(en0), .Slt(slt0), .Level(lvl0), .Empty(emp0), .Full(full0)
`ifdef COUNT_REQ_QUEUE_DROP_CNT_EN
        , .Drop_Cnt(drop0)
`endif
    );

    count_req_queue #(.DEPTH(DEPTH), .GAP(2)) u_gap2 (
        .Clk(Clk), .Reset(Reset), .In_Valid(v2), .In_Slt(s2), .In_Ready(rdy2),
        .Hold(h2), .En(en2), .Slt(slt2), .Level(lvl2), .Empty(emp2), .Full(full2)
`ifdef COUNT_REQ_QUEUE_DROP_CNT_EN
        , .Drop_Cnt(drop2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic mon0();
        forever begin
            @(negedge Clk);
            if (en0 === 1'b1) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL u_gap0 unexpected pulse: Slt=%0d, expected no pulse", slt0);
                end else begin
                    logic e;
                    e = q0.pop_front();
                    chk("u_gap0 pulse Slt", slt0, e);
                end
            end
        end
    endtask

    task automatic mon2();
        forever begin
            @(negedge Clk);
            if (en2 === 1'b1) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL u_gap2 unexpected pulse: Slt=%0d, expected no pulse", slt2);
                end else begin
                    logic e;
                    e = q2.pop_front();
                    chk("u_gap2 pulse Slt", slt2, e);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        v0 = 1'b0; s0 = 1'b0; h0 = 1'b0;
        v2 = 1'b0; s2 = 1'b0; h2 = 1'b0;
        fork
            mon0();
            mon2();
        join_none

        // Reset state
        tick();
        tick();
        chk("reset En", en0, 0);
        chk("reset Slt", slt0, 0);
        chk("reset Level", lvl0, 0);
        chk("reset Empty", emp0, 1);
        chk("reset Full", full0, 0);
        chk("reset In_Ready", rdy0, 1);
        chk("reset gap2 En", en2, 0);
        chk("reset gap2 Level", lvl2, 0);
        Reset = 1'b0;

        // GAP=0 back-to-back burst; edges 2..4 are simultaneous push+pop
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1;
            s0 = seq1[i];
            q0.push_back(seq1[i]);
            tick();
            chk("burst En", en0, (i == 0) ? 0 : 1);
            chk("burst push+pop Level", lvl0, 1);
        end
        v0 = 1'b0;
        tick();
        chk("burst last En", en0, 1);
        chk("burst drained Level", lvl0, 0);
        chk("burst drained Empty", emp0, 1);
        tick();
        chk("burst after En", en0, 0);

        // Fill with Hold: 8 accepted, 2 refused
        h0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v0 = 1'b1;
            s0 = pat3[i];
            chk("fill In_Ready", rdy0, (i < 8) ? 1 : 0);
            if (i < 8) q0.push_back(pat3[i]);
            tick();
            chk("fill held En", en0, 0);
        end
        v0 = 1'b0;
        chk("fill Level", lvl0, 8);
        chk("fill Full", full0, 1);
        chk("fill In_Ready low", rdy0, 0);
`ifdef COUNT_REQ_QUEUE_DROP_CNT_EN
        chk("fill Drop_Cnt", drop0, 2);
`endif
        h0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("drain En", en0, 1);
            chk("drain Level", lvl0, 8 - k);
        end
        tick();
        chk("drain done En", en0, 0);
        chk("drain done Empty", emp0, 1);

        // Hold asserted mid-burst
        h0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v0 = 1'b1;
            s0 = pat5[i];
            q0.push_back(pat5[i]);
            tick();
        end
        v0 = 1'b0;
        chk("hold queued Level", lvl0, 5);
        h0 = 1'b0;
        tick();
        chk("hold run1 En", en0, 1);
        chk("hold run1 Level", lvl0, 4);
        tick();
        chk("hold run2 En", en0, 1);
        chk("hold run2 Level", lvl0, 3);
        h0 = 1'b1;
        tick();
        chk("hold stop En", en0, 0);
        chk("hold stop Level", lvl0, 3);
        tick();
        chk("hold frozen En", en0, 0);
        chk("hold frozen Level", lvl0, 3);
        h0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("hold resume En", en0, 1);
            chk("hold resume Level", lvl0, 3 - k);
        end
        tick();
        chk("hold done En", en0, 0);

        // GAP=2 spacing: 3 queued, pulses three cycles apart
        h2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v2 = 1'b1;
            s2 = pat2[i];
            q2.push_back(pat2[i]);
            tick();
        end
        v2 = 1'b0;
        chk("gap queued Level", lvl2, 3);
        h2 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("gap En", en2, en_exp2[j]);
            chk("gap Level", lvl2, lvl_exp2[j]);
        end

        // Reset while Level=5 and a gap is running
        h2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v2 = 1'b1;
            s2 = pat6[i];
            q2.push_back(pat6[i]);
            tick();
        end
        h2 = 1'b0;
        s2 = 1'b0;
        q2.push_back(1'b0);
        tick();
        chk("prereset En", en2, 1);
        chk("prereset Level", lvl2, 5);
        v2 = 1'b0;
        Reset = 1'b1;
        tick();
        q2.delete();
        chk("midreset En", en2, 0);
        chk("midreset Level", lvl2, 0);
        chk("midreset Empty", emp2, 1);
        chk("midreset In_Ready", rdy2, 1);
        Reset = 1'b0;
        v2 = 1'b1;
        s2 = 1'b1;
        q2.push_back(1'b1);
        tick();
        v2 = 1'b0;
        chk("postreset push En", en2, 0);
        chk("postreset push Level", lvl2, 1);
        tick();
        chk("postreset issue En", en2, 1);
        chk("postreset issue Level", lvl2, 0);
        tick();
        chk("postreset idle En", en2, 0);

        // Every accepted request must have produced its pulse
        chk("u_gap0 pending", q0.size(), 0);
        chk("u_gap2 pending", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count_req_queue.md
Name: count_req_queue

Overview:
- Upstream request buffer for the dual-register event counter stage.
- Accepts count requests from a producer over a valid/ready handshake. Each request is a 1-bit select (0 = register 0, 1 = register 1).
- Buffers requests in a small FIFO. Replays them as single-cycle En pulses with a matching Slt, with a configurable minimum idle gap between pulses.
- Decouples bursty event sources from the counter, which consumes at most one increment per enabled cycle.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- GAP, 0, minimum idle cycles forced between consecutive En pulses; 0 allows back-to-back pulses.

Ports:
- Clk  input  1  clock.
- Reset  input  1  reset.
- In_Valid  input  1  producer has a request.
- In_Slt  input  1  select bit of the offered request.
- In_Ready  output  1  queue can accept; equals !Full.
- Hold  input  1  pauses issuing new pulses; does not affect accepting requests.
- En  output  1  registered one-cycle increment pulse to the counter.
- Slt  output  1  registered select; valid while En=1, holds its last value otherwise.
- Level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Empty  output  1  Level==0.
- Full  output  1  Level==DEPTH.

Behaviour:
- Reset: synchronous, active-high, Reset on Clk. Clock is Clk. Reset clears rd/wr pointers and Level, and sets FSM=IDLE, En=0, Slt=0, gap counter=0. Reset asserted mid-operation discards all queued entries and any in-progress gap; En is 0 in the cycle after the reset edge.
- Push: occurs on an edge where In_Valid && In_Ready. In_Slt is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- In_Ready is combinational from Level: !Full. No full-bypass: a push is never accepted while Full, even if a pop occurs on the same edge.
- Pop: occurs on an edge where the FSM issues. Head is read at rd_ptr; rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop: Level is unchanged and both pointers advance.
- FSM state IDLE:
  - If !Empty && !Hold: pop, register En=1 and Slt=head. Then go to GAP with gap counter=GAP if GAP>0; otherwise remain in IDLE.
  - Else: En=0.
- FSM state GAP:
  - En=0.
  - Decrement the gap counter. When it reaches 1, return to IDLE on that edge.
  - Hold does not extend or abort a gap in progress.
- Latency:
  - A request pushed at edge t can be popped at edge t+1 at the earliest. En is therefore high in the cycle after edge t+1.
  - A push into an empty queue is never issued on the same edge.
- Throughput: one pulse per GAP+1 cycles.
- Ordering: strict FIFO; each accepted request produces exactly one En pulse.
- Level/Empty/Full: registered and consistent with the pointers after every edge.

Optional Feature:
- Macro: COUNT_REQ_QUEUE_DROP_CNT_EN.
- Defined:
  - Adds output Drop_Cnt[15:0], incremented on every edge where In_Valid && Full, saturating at 16'hFFFF.
  - Cleared by Reset.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - SLT_REG0=1'b0 and SLT_REG1=1'b1 constants.
  - The FSM state typedef (IDLE, GAP).
  - A level-width helper function.
- One natural sub-module: sync_fifo_1b. It is the pointer/Level/storage FIFO with push/pop/full/empty. The issue FSM and gap counter stay in the top level.

Test Plan:
- Reset, GAP=0: push Slt sequence 0,1,1,0 back-to-back -> four consecutive En pulses with Slt 0,1,1,0; first En two cycles after the first push edge; Empty=1 afterwards.
- GAP=2: push 3 requests in a burst -> En pulses spaced exactly 3 cycles apart; Level steps 3→2→1→0.
- Fill: DEPTH=8 with Hold=1, offer 10 requests -> In_Ready drops after 8; Full=1, Level=8. With the macro defined, Drop_Cnt=2. Release Hold -> 8 pulses in order.
- Push into an empty queue while the FSM pops the last entry (simultaneous push/pop) -> Level stays 1 and no entry is lost or duplicated.
- Assert Hold mid-burst with 5 queued and GAP=0 -> En stops the cycle after Hold is sampled; Level is frozen; deassert -> remaining entries issue in order.
- Assert Reset while Level=5 and in GAP -> next cycle En=0, Level=0, Empty=1, In_Ready=1; subsequent push issues normally.
